// File: rtl/bitlet_pkg.sv
// Shared constants and level-count helpers for the bitlet shift-add tree.
// rows_at() gives the row count entering a given 4:2 reduction level.
package bitlet_pkg;

  localparam int N_IN_DEF  = 24;
  localparam int W_IN_DEF  = 12;
  localparam int W_SUM_DEF = 48;

  // A lone group of 3 rows is padded with a zero row so the
  // reduction still converges (3 -> 2).
  function automatic int next_rows(input int r);
    return (r == 3) ? 2 : 2 * (r / 4) + (r % 4);
  endfunction

  function automatic int rows_at(input int n, input int lvl);
    int r;
    r = n;
    for (int k = 0; k < lvl; k++) r = next_rows(r);
    return r;
  endfunction

  function automatic int num_levels(input int n);
    int r;
    int lv;
    r  = n;
    lv = 0;
    for (int k = 0; k < 32; k++) begin
      if (r > 2) begin
        r  = next_rows(r);
        lv = lv + 1;
      end
    end
    return lv;
  endfunction

endpackage

// File: rtl/bitlet_csa42.sv
// 4:2 carry-save compressor: a+b+c+d == sum+cry (mod 2^W).
// Ports: a,b,c,d rows in; sum row and carry row (already shifted) out.
module bitlet_csa42 #(
  parameter int W = 48
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] sum,
  output logic [W-1:0] cry
);

  logic [W-1:0] s1;
  logic [W-1:0] c1;

  always_comb begin
    s1  = a ^ b ^ c;
    c1  = ((a & b) | (a & c) | (b & c)) << 1;
    sum = s1 ^ d ^ c1;
    cry = ((s1 & d) | (s1 & c1) | (d & c1)) << 1;
  end

endmodule

// File: rtl/bitlet_shift_add_tree.sv
// Pipelined shift-add reduction tree with group accumulator.
// Ports: clk/rst_n; in_vld/in_rdy/in_vec/in_shift/in_first/in_last;
//        out_vld/out_rdy/out_sum.
module bitlet_shift_add_tree
  import bitlet_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int W_IN  = W_IN_DEF,
  parameter int W_SUM = W_SUM_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [N_IN*W_IN-1:0]   in_vec,
  input  logic                   in_shift,
  input  logic                   in_first,
  input  logic                   in_last,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [W_SUM-1:0]       out_sum
);

  localparam int LV = num_levels(N_IN);

  logic             en;
  logic             out_vld_q, out_vld_d;
  logic [W_SUM-1:0] acc_q, acc_d;

  logic [W_SUM-1:0] ext_rows [N_IN];
  logic [W_IN-1:0]  op;
  logic [W_SUM-1:0] sx;

  assign en     = !out_vld_q | out_rdy;
  assign in_rdy = en;

  always_comb begin
    op = '0;
    sx = '0;
    for (int i = 0; i < N_IN; i++) begin
      op = in_vec[i*W_IN +: W_IN];
      sx = {{(W_SUM-W_IN){op[W_IN-1]}}, op};
      ext_rows[i] = in_shift ? (sx << i) : sx;
    end
  end

  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int RI = rows_at(N_IN, l);
    localparam int RO = rows_at(N_IN, l + 1);
    localparam int NC = (RI == 3) ? 1 : RI / 4;
    localparam int NP = (RI == 3) ? 0 : RI % 4;

    logic [W_SUM-1:0] src   [RI];
    logic [W_SUM-1:0] row_d [RO];
    logic [W_SUM-1:0] row_q [RO];
    logic             src_vld, src_fst, src_lst;
    logic             vld_q, fst_q, lst_q;
    logic             vld_d, fst_d, lst_d;

    if (l == 0) begin : g_src
      for (genvar j = 0; j < RI; j++) begin : g_j
        assign src[j] = ext_rows[j];
      end
      assign src_vld = in_vld;
      assign src_fst = in_first;
      assign src_lst = in_last;
    end else begin : g_src
      for (genvar j = 0; j < RI; j++) begin : g_j
        assign src[j] = g_lvl[l-1].row_q[j];
      end
      assign src_vld = g_lvl[l-1].vld_q;
      assign src_fst = g_lvl[l-1].fst_q;
      assign src_lst = g_lvl[l-1].lst_q;
    end

    if (RI == 3) begin : g_c3
      bitlet_csa42 #(.W(W_SUM)) u_csa (
        .a   (src[0]),
        .b   (src[1]),
        .c   (src[2]),
        .d   ('0),
        .sum (row_d[0]),
        .cry (row_d[1])
      );
    end else begin : g_cn
      for (genvar c = 0; c < NC; c++) begin : g_c
        bitlet_csa42 #(.W(W_SUM)) u_csa (
          .a   (src[4*c+0]),
          .b   (src[4*c+1]),
          .c   (src[4*c+2]),
          .d   (src[4*c+3]),
          .sum (row_d[2*c]),
          .cry (row_d[2*c+1])
        );
      end
      for (genvar p = 0; p < NP; p++) begin : g_p
        assign row_d[2*NC+p] = src[4*NC+p];
      end
    end

    always_comb begin
      vld_d = vld_q;
      fst_d = fst_q;
      lst_d = lst_q;
      if (en) begin
        vld_d = src_vld;
        fst_d = src_fst;
        lst_d = src_lst;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        fst_q <= 1'b0;
        lst_q <= 1'b0;
      end else begin
        vld_q <= vld_d;
        fst_q <= fst_d;
        lst_q <= lst_d;
      end
    end

    // Row data is only observed through a valid stage.
    always_ff @(posedge clk) begin
      if (en) row_q <= row_d;
    end
  end

  logic             t_vld, t_fst, t_lst;
  logic [W_SUM-1:0] t_r0, t_r1;

  assign t_vld = g_lvl[LV-1].vld_q;
  assign t_fst = g_lvl[LV-1].fst_q;
  assign t_lst = g_lvl[LV-1].lst_q;
  assign t_r0  = g_lvl[LV-1].row_q[0];
  assign t_r1  = g_lvl[LV-1].row_q[1];

  always_comb begin
    acc_d     = acc_q;
    out_vld_d = out_vld_q;
    if (en) begin
      out_vld_d = t_vld & t_lst;
      if (t_vld) acc_d = (t_fst ? '0 : acc_q) + t_r1 + t_r0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign out_vld = out_vld_q;
  assign out_sum = acc_q;

endmodule

// File: tb/tb_bitlet_shift_add_tree.sv
// Scoreboard bench for bitlet_shift_add_tree (N_IN=24 and N_IN=8).
// Expected sums come from a plain-arithmetic reference model.
module tb_bitlet_shift_add_tree;

  localparam int LA = 5;
  localparam int LB = 3;

  typedef int ops_t [32];
  typedef struct {
    longint sum;
    int     acc_cyc;
    bit     chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic          a_in_vld = 0, a_in_rdy, a_in_shift = 0;
  logic          a_in_first = 0, a_in_last = 0;
  logic [287:0]  a_in_vec = '0;
  logic          a_out_vld, a_out_rdy = 1;
  logic [47:0]   a_out_sum;

  logic          b_in_vld = 0, b_in_rdy, b_in_shift = 0;
  logic          b_in_first = 0, b_in_last = 0;
  logic [95:0]   b_in_vec = '0;
  logic          b_out_vld, b_out_rdy = 1;
  logic [31:0]   b_out_sum;

  int     cyc = 0;
  int     pass_cnt = 0;
  int     chk_cnt = 0;
  longint macc_a = 0, macc_b = 0;
  exp_t   qa[$];
  exp_t   qb[$];
  bit     a_stall = 0, b_stall = 0;
  longint a_prev = 0, b_prev = 0;
  bit     rnd_busy = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitlet_shift_add_tree #(.N_IN(24), .W_IN(12), .W_SUM(48)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_vec(a_in_vec),
    .in_shift(a_in_shift), .in_first(a_in_first), .in_last(a_in_last),
    .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_sum(a_out_sum)
  );

  bitlet_shift_add_tree #(.N_IN(8), .W_IN(12), .W_SUM(32)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_vec(b_in_vec),
    .in_shift(b_in_shift), .in_first(b_in_first), .in_last(b_in_last),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_sum(b_out_sum)
  );

  function automatic longint norm(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint vsum(input ops_t ops, input int n, input bit sh);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++)
      s += sh ? (longint'(ops[i]) <<< i) : longint'(ops[i]);
    return s;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic send_a(input ops_t ops, input bit sh, f, l, chk);
    bit ok;
    ok = 0;
    for (int i = 0; i < 24; i++) a_in_vec[i*12 +: 12] = ops[i][11:0];
    a_in_shift = sh; a_in_first = f; a_in_last = l; a_in_vld = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (a_in_rdy) begin ok = 1; break; end
    end
    if (!ok) check("a_accept_timeout", 0, 1);
    else begin
      if (f) macc_a = 0;
      macc_a += vsum(ops, 24, sh);
      if (l) qa.push_back('{macc_a, cyc, chk});
    end
    @(posedge clk); #1;
    a_in_vld = 0;
  endtask

  task automatic send_b(input ops_t ops, input bit sh, f, l, chk);
    bit ok;
    ok = 0;
    for (int i = 0; i < 8; i++) b_in_vec[i*12 +: 12] = ops[i][11:0];
    b_in_shift = sh; b_in_first = f; b_in_last = l; b_in_vld = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (b_in_rdy) begin ok = 1; break; end
    end
    if (!ok) check("b_accept_timeout", 0, 1);
    else begin
      if (f) macc_b = 0;
      macc_b += vsum(ops, 8, sh);
      if (l) qb.push_back('{macc_b, cyc, chk});
    end
    @(posedge clk); #1;
    b_in_vld = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 300) begin
      @(posedge clk); #1; k++;
    end
    check(name, qa.size() + qb.size(), 0);
  endtask

  function automatic ops_t fill(input int v);
    ops_t o;
    for (int i = 0; i < 32; i++) o[i] = v;
    return o;
  endfunction

  function automatic int rnd_op();
    int s;
    s = int'($urandom_range(0, 9));
    if (s == 0) return -2048;
    if (s == 1) return 2047;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  function automatic ops_t rnd_ops();
    ops_t o;
    for (int i = 0; i < 32; i++) o[i] = rnd_op();
    return o;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) a_stall = 0;
    else begin
      if (a_out_vld && a_out_rdy) begin
        if (qa.size() == 0) check("a_unexpected_out", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_sum", norm(longint'(a_out_sum), 48), norm(e.sum, 48));
          if (e.chk_lat) check("a_latency", cyc - e.acc_cyc, LA);
        end
      end
      if (a_stall) begin
        check("a_hold_vld", a_out_vld, 1);
        check("a_hold_sum", longint'(a_out_sum), a_prev);
      end
      if (a_out_vld && !a_out_rdy) begin
        check("a_in_rdy_stall", a_in_rdy, 0);
        a_stall = 1;
        a_prev = longint'(a_out_sum);
      end else a_stall = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) b_stall = 0;
    else begin
      if (b_out_vld && b_out_rdy) begin
        if (qb.size() == 0) check("b_unexpected_out", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_sum", norm(longint'(b_out_sum), 32), norm(e.sum, 32));
          if (e.chk_lat) check("b_latency", cyc - e.acc_cyc, LB);
        end
      end
      if (b_stall) begin
        check("b_hold_vld", b_out_vld, 1);
        check("b_hold_sum", longint'(b_out_sum), b_prev);
      end
      if (b_out_vld && !b_out_rdy) begin
        check("b_in_rdy_stall", b_in_rdy, 0);
        b_stall = 1;
        b_prev = longint'(b_out_sum);
      end else b_stall = 0;
    end
  end

  initial begin
    ops_t o;
    bit   ingrp;
    bit   f, l;

    #2 rst_n = 0;
    #1;
    check("rst_out_vld", a_out_vld, 0);
    check("rst_out_sum", longint'(a_out_sum), 0);
    check("rst_in_rdy", a_in_rdy, 1);
    idle(3);
    rst_n = 1;
    idle(1);

    send_a(fill(1), 1, 1, 1, 1);
    idle(8);
    check("exp_2p24m1", qa.size(), 0);
    send_a(fill(-2048), 0, 1, 1, 1);
    o = fill(0);
    o[0] = -1;
    send_a(o, 1, 1, 1, 1);
    send_a(fill(1), 0, 1, 0, 1);
    send_a(fill(1), 0, 0, 0, 1);
    send_a(fill(1), 0, 0, 1, 1);
    idle(8);
    send_a(fill(1), 0, 0, 1, 1);
    send_a(fill(-2048), 1, 1, 1, 1);
    send_a(fill(2047), 1, 1, 1, 1);
    drain("drain_directed");

    fork
      begin
        for (int n = 0; n < 6; n++) send_a(rnd_ops(), n[0], 1, 1, 0);
      end
      begin
        idle(6);
        a_out_rdy = 0;
        idle(4);
        a_out_rdy = 1;
      end
    join
    drain("drain_stall");

    rnd_busy = 1;
    ingrp = 0;
    fork
      begin
        for (int n = 0; n < 50; n++) begin
          f = ingrp ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
          l = ($urandom_range(0, 2) == 0);
          ingrp = !l;
          send_a(rnd_ops(), 1'($urandom_range(0, 1)), f, l, 0);
          if ($urandom_range(0, 4) == 0) idle(1);
        end
        send_a(rnd_ops(), 1, 0, 1, 0);
        rnd_busy = 0;
      end
      begin
        while (rnd_busy) begin
          @(posedge clk); #1;
          a_out_rdy = ($urandom_range(0, 2) != 0);
        end
        a_out_rdy = 1;
      end
    join
    drain("drain_rand_a");

    ingrp = 0;
    for (int n = 0; n < 60; n++) begin
      f = ingrp ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 2) == 0);
      ingrp = !l;
      send_b(rnd_ops(), 1'($urandom_range(0, 1)), f, l, 1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
    end
    send_b(fill(-2048), 1, 1, 1, 1);
    send_b(fill(-2048), 0, 0, 1, 1);
    drain("drain_rand_b");

    send_a(fill(1), 0, 1, 0, 0);
    send_a(fill(1), 0, 0, 0, 0);
    idle(8);
    send_a(fill(1), 0, 0, 1, 0);
    #2 rst_n = 0;
    #1;
    check("mid_rst_out_vld", a_out_vld, 0);
    check("mid_rst_out_sum", longint'(a_out_sum), 0);
    check("mid_rst_in_rdy", a_in_rdy, 1);
    qa.delete();
    qb.delete();
    macc_a = 0;
    macc_b = 0;
    idle(2);
    rst_n = 1;
    idle(1);
    send_a(fill(1), 0, 1, 1, 1);
    idle(10);
    drain("drain_after_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
